// File: rtl/rf_pkg.sv
// Shared constants and helpers for the rf_sb register file and its scoreboard.
package rf_pkg;

  localparam int unsigned RF_NREGS   = 8;
  localparam int unsigned RF_WIDTH   = 16;
  localparam int unsigned RF_RST_VAL = 0;

  // Address width needed to index n registers.
  function automatic int unsigned rf_aw(input int unsigned n);
    return $clog2(n);
  endfunction

endpackage

// File: rtl/rf_scoreboard.sv
// Per-register busy bits for outstanding loads: set on issue, cleared on load return,
// with set-over-clear priority and double-issue detection.
module rf_scoreboard
  import rf_pkg::*;
#(
  parameter  int unsigned NREGS   = RF_NREGS,
  parameter  int unsigned ZERO_R0 = 0,
  localparam int unsigned AW      = rf_aw(NREGS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          set_en,
  input  logic [AW-1:0] set_addr,
  input  logic          clr_en,
  input  logic [AW-1:0] clr_addr,
  input  logic [AW-1:0] ra,
  input  logic [AW-1:0] rb,
  input  logic [AW-1:0] rd,
  output logic          busy_a,
  output logic          busy_b,
  output logic          busy_d,
  output logic          dbl_issue
);

  logic [NREGS-1:0] busy;
  logic             set_eff;

  // Issues to a hardwired-zero r0 are ignored entirely.
  always_comb begin
    set_eff   = set_en && !((ZERO_R0 != 0) && (set_addr == '0));
    dbl_issue = set_eff && busy[set_addr] && !(clr_en && (clr_addr == set_addr));
  end

  // Set is applied after clear so an issue wins over a same-cycle load return.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy <= '0;
    end else begin
      if (clr_en)  busy[clr_addr] <= 1'b0;
      if (set_eff) busy[set_addr] <= 1'b1;
    end
  end

  assign busy_a = busy[ra];
  assign busy_b = busy[rb];
  assign busy_d = busy[rd];

endmodule

// File: rtl/rf_sb.sv
// Multi-port register file with ALU and load-return write ports, busy scoreboard and
// sticky collision flag. Define RF_BYPASS_EN for same-cycle write-to-read forwarding.
module rf_sb
  import rf_pkg::*;
#(
  parameter  int unsigned NREGS   = RF_NREGS,
  parameter  int unsigned WIDTH   = RF_WIDTH,
  parameter  int unsigned ZERO_R0 = 0,
  localparam int unsigned AW      = rf_aw(NREGS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [AW-1:0]    ra,
  input  logic [AW-1:0]    rb,
  input  logic [AW-1:0]    rd,
  output logic [WIDTH-1:0] opA,
  output logic [WIDTH-1:0] opB,
  output logic [WIDTH-1:0] opD,
  input  logic             we,
  input  logic [AW-1:0]    wa,
  input  logic [WIDTH-1:0] wdata,
  input  logic             lwe,
  input  logic [AW-1:0]    lwa,
  input  logic [WIDTH-1:0] ldata,
  input  logic             iss_valid,
  input  logic [AW-1:0]    iss_rd,
  output logic             busy_a,
  output logic             busy_b,
  output logic             busy_d,
  output logic             err_coll
);

  logic [WIDTH-1:0] mem [NREGS];
  logic             we_eff;
  logic             lwe_eff;
  logic             coll;
  logic             dbl_issue;
  logic [AW-1:0]    raddr [3];
  logic [WIDTH-1:0] rdata [3];
  logic [2:0]       busy_raw;
  logic [2:0]       busy_out;

  // Writes to a hardwired-zero r0 are dropped and never count as a collision.
  always_comb begin
    we_eff  = we  && !((ZERO_R0 != 0) && (wa  == '0));
    lwe_eff = lwe && !((ZERO_R0 != 0) && (lwa == '0));
    coll    = we_eff && lwe_eff && (wa == lwa);
  end

  // ALU write is applied last so it wins a same-address collision.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(NREGS); i++) mem[i] <= WIDTH'(RF_RST_VAL);
    end else begin
      if (lwe_eff) mem[lwa] <= ldata;
      if (we_eff)  mem[wa]  <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst)                    err_coll <= 1'b0;
    else if (coll || dbl_issue) err_coll <= 1'b1;
  end

  rf_scoreboard #(
    .NREGS   (NREGS),
    .ZERO_R0 (ZERO_R0)
  ) u_sb (
    .clk       (clk),
    .rst       (rst),
    .set_en    (iss_valid),
    .set_addr  (iss_rd),
    .clr_en    (lwe_eff),
    .clr_addr  (lwa),
    .ra        (ra),
    .rb        (rb),
    .rd        (rd),
    .busy_a    (busy_raw[0]),
    .busy_b    (busy_raw[1]),
    .busy_d    (busy_raw[2]),
    .dbl_issue (dbl_issue)
  );

  assign raddr[0] = ra;
  assign raddr[1] = rb;
  assign raddr[2] = rd;

  // Read muxes, with optional forwarding of this cycle's write data.
  always_comb begin
    for (int p = 0; p < 3; p++) begin
      rdata[p]    = mem[raddr[p]];
      busy_out[p] = busy_raw[p];
`ifdef RF_BYPASS_EN
      if (we_eff && (wa == raddr[p]))         rdata[p] = wdata;
      else if (lwe_eff && (lwa == raddr[p]))  rdata[p] = ldata;
      if (lwe_eff && (lwa == raddr[p]) && !(iss_valid && (iss_rd == raddr[p])))
        busy_out[p] = 1'b0;
`endif
      if ((ZERO_R0 != 0) && (raddr[p] == '0)) rdata[p] = '0;
    end
  end

  assign opA    = rdata[0];
  assign opB    = rdata[1];
  assign opD    = rdata[2];
  assign busy_a = busy_out[0];
  assign busy_b = busy_out[1];
  assign busy_d = busy_out[2];

endmodule

// File: tb/tb_rf_sb.sv
// Directed self-checking bench for rf_sb: one default instance and one with ZERO_R0=1
// driven by the same stimulus.
module tb_rf_sb;

  localparam int unsigned AW = 3;
  localparam int unsigned W  = 16;
`ifdef RF_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] ra, rb, rd, wa, lwa, iss_rd;
  logic          we, lwe, iss_valid;
  logic [W-1:0]  wdata, ldata;

  logic [W-1:0]  opA, opB, opD, zopA, zopB, zopD;
  logic          busy_a, busy_b, busy_d, err_coll;
  logic          zbusy_a, zbusy_b, zbusy_d, zerr_coll;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  rf_sb #(.NREGS(8), .WIDTH(16), .ZERO_R0(0)) dut (
    .clk(clk), .rst(rst), .ra(ra), .rb(rb), .rd(rd),
    .opA(opA), .opB(opB), .opD(opD),
    .we(we), .wa(wa), .wdata(wdata), .lwe(lwe), .lwa(lwa), .ldata(ldata),
    .iss_valid(iss_valid), .iss_rd(iss_rd),
    .busy_a(busy_a), .busy_b(busy_b), .busy_d(busy_d), .err_coll(err_coll)
  );

  rf_sb #(.NREGS(8), .WIDTH(16), .ZERO_R0(1)) dutz (
    .clk(clk), .rst(rst), .ra(ra), .rb(rb), .rd(rd),
    .opA(zopA), .opB(zopB), .opD(zopD),
    .we(we), .wa(wa), .wdata(wdata), .lwe(lwe), .lwa(lwa), .ldata(ldata),
    .iss_valid(iss_valid), .iss_rd(iss_rd),
    .busy_a(zbusy_a), .busy_b(zbusy_b), .busy_d(zbusy_d), .err_coll(zerr_coll)
  );

  task automatic chk16(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Advance past one rising edge and settle away from it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    we = 1'b0; lwe = 1'b0; iss_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; ra = '0; rb = '0; rd = '0; wa = '0; lwa = '0; iss_rd = '0;
    wdata = '0; ldata = '0;
    idle();
    tick(); tick();
    rst = 1'b0;

    // Reset state on every address.
    for (int i = 0; i < 8; i++) begin
      ra = AW'(i); rb = AW'(i); rd = AW'(i);
      #1;
      chk16("rst_opA", opA, 16'h0000);
      chk16("rst_opB", opB, 16'h0000);
      chk16("rst_opD", opD, 16'h0000);
      chk1("rst_busy_a", busy_a, 1'b0);
      chk1("rst_busy_b", busy_b, 1'b0);
      chk1("rst_busy_d", busy_d, 1'b0);
    end
    chk1("rst_err", err_coll, 1'b0);

    // ALU write to r3.
    we = 1'b1; wa = 3'd3; wdata = 16'h1234; ra = 3'd3;
    #1;
    chk16("wr_same_cycle_opA", opA, BYP ? 16'h1234 : 16'h0000);
    tick(); idle();
    chk16("wr_next_cycle_opA", opA, 16'h1234);

    // Issue to r5, load return three cycles later.
    iss_valid = 1'b1; iss_rd = 3'd5;
    tick(); idle();
    rb = 3'd5;
    #1;
    chk1("iss_busy_b", busy_b, 1'b1);
    tick(); tick();
    chk1("iss_busy_b_hold", busy_b, 1'b1);
    lwe = 1'b1; lwa = 3'd5; ldata = 16'hBEEF;
    #1;
    chk1("ld_same_busy_b", busy_b, BYP ? 1'b0 : 1'b1);
    chk16("ld_same_opB", opB, BYP ? 16'hBEEF : 16'h0000);
    tick(); idle();
    chk1("ld_busy_b", busy_b, 1'b0);
    chk16("ld_opB", opB, 16'hBEEF);
    chk1("ld_err", err_coll, 1'b0);

    // Dual write to distinct addresses.
    we = 1'b1; wa = 3'd1; wdata = 16'h1111;
    lwe = 1'b1; lwa = 3'd4; ldata = 16'h4444;
    tick(); idle();
    ra = 3'd1; rb = 3'd4;
    #1;
    chk16("dual_opA", opA, 16'h1111);
    chk16("dual_opB", opB, 16'h4444);
    chk1("dual_err", err_coll, 1'b0);

    // Same-address collision: ALU data wins, sticky error.
    we = 1'b1; wa = 3'd2; wdata = 16'hAAAA;
    lwe = 1'b1; lwa = 3'd2; ldata = 16'h5555;
    tick(); idle();
    ra = 3'd2;
    #1;
    chk16("coll_opA", opA, 16'hAAAA);
    chk1("coll_err", err_coll, 1'b1);
    tick(); tick(); tick();
    chk1("coll_err_sticky", err_coll, 1'b1);

    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    chk1("coll_err_rst", err_coll, 1'b0);
    chk16("coll_opA_rst", opA, 16'h0000);

    // Issue and load return on r6 in the same cycle, then a double issue.
    iss_valid = 1'b1; iss_rd = 3'd6;
    tick(); idle();
    lwe = 1'b1; lwa = 3'd6; ldata = 16'h0606;
    iss_valid = 1'b1; iss_rd = 3'd6;
    tick(); idle();
    rd = 3'd6;
    #1;
    chk1("setclr_busy_d", busy_d, 1'b1);
    chk1("setclr_err", err_coll, 1'b0);
    chk16("setclr_opD", opD, 16'h0606);
    iss_valid = 1'b1; iss_rd = 3'd6;
    tick(); idle();
    chk1("dbl_err", err_coll, 1'b1);
    chk1("dbl_busy_d", busy_d, 1'b1);

    // ZERO_R0 behaviour against the plain instance.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    we = 1'b1; wa = 3'd0; wdata = 16'hFFFF;
    tick(); idle();
    ra = 3'd0;
    #1;
    chk16("z_wr_opA", zopA, 16'h0000);
    chk16("nz_wr_opA", opA, 16'hFFFF);
    iss_valid = 1'b1; iss_rd = 3'd0;
    tick(); idle();
    chk1("z_iss_busy_a", zbusy_a, 1'b0);
    chk1("nz_iss_busy_a", busy_a, 1'b1);
    iss_valid = 1'b1; iss_rd = 3'd0;
    tick(); idle();
    chk1("z_dbl_err", zerr_coll, 1'b0);
    chk1("nz_dbl_err", err_coll, 1'b1);
    we = 1'b1; wa = 3'd0; wdata = 16'h0101;
    lwe = 1'b1; lwa = 3'd0; ldata = 16'h0202;
    tick(); idle();
    chk1("z_coll_err", zerr_coll, 1'b0);
    chk16("z_coll_opA", zopA, 16'h0000);

    // Reset mid-sequence clears data and busy bits.
    iss_valid = 1'b1; iss_rd = 3'd7;
    we = 1'b1; wa = 3'd3; wdata = 16'hC0DE;
    tick(); idle();
    rd = 3'd7; rb = 3'd3;
    #1;
    chk1("z_pre_rst_busy_d", zbusy_d, 1'b1);
    chk16("z_pre_rst_opB", zopB, 16'hC0DE);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    chk1("z_rst_busy_d", zbusy_d, 1'b0);
    chk16("z_rst_opB", zopB, 16'h0000);
    chk1("z_rst_err", zerr_coll, 1'b0);
    chk16("nz_rst_opA", opA, 16'h0000);
    chk1("nz_rst_busy_a", busy_a, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rf_sb.md
Name: rf_sb

Overview:
Parametrised multi-port register file, the successor to the 4x16 register file. It has a configurable register count and width, and three combinational read ports (A, B, D). It has two write ports: the ALU writeback port and the load-return port. A per-register busy scoreboard tracks registers with an outstanding load, and a sticky error flag records write-port collisions. It sits between decode, ALU writeback and the load/store unit of the 16-bit datapath.

Parameters:
NREGS, 8, number of registers; must be a power of 2 and at least 2
WIDTH, 16, register and data width in bits
ZERO_R0, 0, when 1, register 0 reads as zero, ignores writes and is never marked busy
AW, $clog2(NREGS), local (derived) parameter, register address width; not overridable

Ports:
clk  in  1  clock; all state updates on the rising edge
rst  in  1  reset, synchronous, active-high
ra  in  AW  read address, port A
rb  in  AW  read address, port B
rd  in  AW  read address, port D (destination operand)
opA  out  WIDTH  data for ra
opB  out  WIDTH  data for rb
opD  out  WIDTH  data for rd
we  in  1  ALU write enable
wa  in  AW  ALU write address
wdata  in  WIDTH  ALU write data
lwe  in  1  load-return write enable
lwa  in  AW  load-return write address
ldata  in  WIDTH  load-return data
iss_valid  in  1  a load has issued; mark iss_rd busy
iss_rd  in  AW  destination of the issued load
busy_a  out  1  busy bit of ra
busy_b  out  1  busy bit of rb
busy_d  out  1  busy bit of rd
err_coll  out  1  sticky flag: write-port collision or double issue

Behaviour:
- Reset (rst=1 at a clock edge): all registers are cleared to 0, all busy bits to 0, and err_coll to 0. Reset overrides every other input in that cycle.
- Reads are combinational from the register array. Without bypass, a write becomes visible on the read ports the cycle after the write edge.
- ALU write: when we=1, r[wa] <= wdata at the clock edge. It does not change busy bits.
- Load write: when lwe=1, r[lwa] <= ldata and busy[lwa] <= 0.
- Both write ports target the same address (we & lwe & wa==lwa):
  - the ALU data is written;
  - busy[lwa] is still cleared;
  - err_coll is set.
- Different addresses on the two write ports: both writes happen in the same cycle.
- Issue: when iss_valid=1, busy[iss_rd] <= 1.
- Issue and load-return clear on the same register in the same cycle: the set wins, and busy stays 1.
- Issue to a register that is already busy and not being cleared that cycle: busy stays 1 and err_coll is set.
- busy_a/b/d are combinational lookups of the busy bits. Stall decisions belong to the consumer.
- ZERO_R0=1:
  - opX reads 0 for address 0;
  - writes to address 0 are dropped and do not count toward a collision;
  - iss_rd=0 never sets busy and never flags a double issue.
- err_coll is sticky: it stays 1 until the next reset.

Optional Feature:
RF_BYPASS_EN
- Defined:
  - Each read port returns the write data in the same cycle when its address matches an active write. Collision priority applies: ALU data over load data.
  - busy_x reads 0 in the same cycle as a matching lwe, unless an iss_valid to that register also occurs that cycle.
  - ZERO_R0 still forces 0 on address 0.
- Undefined: reads and busy outputs reflect registered state only, with one cycle of read-after-write latency.

Decomposition:
- Package rf_pkg holds:
  - default constants RF_NREGS=8 and RF_WIDTH=16;
  - the rf_aw(n) address-width function;
  - the reset value constant RF_RST_VAL = 0.
- Sub-module rf_scoreboard(NREGS, ZERO_R0) owns the busy vector, the set/clear priority, double-issue detection and the three busy lookups.
- rf_sb keeps the data array, the write mux with collision detection, the read muxes, the bypass logic and err_coll. It takes the double-issue flag from rf_scoreboard into err_coll.

Test Plan:
- Reset, then read all addresses: all opX=0x0000, all busy_x=0, err_coll=0.
- Write 0x1234 to r3 via we, with ra=3: without bypass, opA=0x1234 one cycle after the write edge; with RF_BYPASS_EN, opA=0x1234 in the write cycle.
- Issue to r5, then rb=5: busy_b=1. Three cycles later, lwe to r5 with 0xBEEF: the next cycle busy_b=0 and opB=0xBEEF.
- we to r2 with 0xAAAA and lwe to r2 with 0x5555 in the same cycle: r2=0xAAAA, err_coll=1, and err_coll stays 1 until rst.
- r6 busy; lwe to r6 and iss_valid to r6 in the same cycle: busy stays 1 and err_coll stays 0. A second iss_valid to r6 the next cycle sets err_coll=1.
- ZERO_R0=1: we to r0 with 0xFFFF, then ra=0 gives opA=0. iss_rd=0 gives busy_a=0. rst asserted mid-sequence clears all registers and busy bits on that edge.
